// File: rtl/bicubic_phase_serializer.sv
// Serializes one group of four bicubic phase sums into rounded, clamped 8-bit pixels.
// Optional clamp-event counter on port sat_cnt when BICUBIC_SAT_COUNT_EN is defined.

module bicubic_round_clamp #(
  parameter int IN_W  = 16,
  parameter int FRAC  = 7,
  parameter int PIX_W = 8
) (
  input  logic [IN_W-1:0]  ws,
  output logic [PIX_W-1:0] pix
`ifdef BICUBIC_SAT_COUNT_EN
  ,
  output logic             sat
`endif
);
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(2**(FRAC-1));
  localparam logic signed [IN_W:0] PMAX = (IN_W+1)'(2**PIX_W - 1);

  logic signed [IN_W:0] s, r;
  logic                 lo, hi;

  // one extra bit of headroom keeps s+HALF from overflowing at the positive limit
  assign s  = $signed({ws[IN_W-1], ws});
  assign r  = (s + HALF) >>> FRAC;
  assign lo = r < 0;
  assign hi = r > PMAX;

  always_comb begin
    pix = r[PIX_W-1:0];
    if (lo)      pix = '0;
    else if (hi) pix = '1;
  end

`ifdef BICUBIC_SAT_COUNT_EN
  assign sat = lo | hi;
`endif
endmodule

module bicubic_phase_serializer #(
  parameter int IN_W  = 16,
  parameter int FRAC  = 7,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  ws_0,
  input  logic [IN_W-1:0]  ws_1,
  input  logic [IN_W-1:0]  ws_2,
  input  logic [IN_W-1:0]  ws_3,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic [1:0]       out_phase,
  output logic             out_last
`ifdef BICUBIC_SAT_COUNT_EN
  ,
  output logic [15:0]      sat_cnt
`endif
);
  localparam int NUM_PH = 4;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                          state_q, state_d;
  logic [1:0]                      ph;
  logic [NUM_PH-1:0][IN_W-1:0]     h;
  logic                            last_r;
  logic [NUM_PH-1:0][PIX_W-1:0]    pix_ph;
  logic                            accept, xfer, ph_end;

  assign ph_end = (ph == 2'd3);
  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EMIT;
      EMIT:    if (xfer && ph_end) state_d = accept ? EMIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready opens on the final transfer so the next group loads without a bubble
  always_comb begin
    out_valid = (state_q == EMIT);
    in_ready  = (state_q == IDLE) | (out_ready & ph_end);
    out_phase = ph;
    out_last  = last_r & ph_end;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h      <= '0;
      last_r <= 1'b0;
      ph     <= 2'd0;
    end else if (accept) begin
      h      <= {ws_3, ws_2, ws_1, ws_0};
      last_r <= in_last;
      ph     <= 2'd0;
    end else if (xfer) begin
      ph     <= ph + 2'd1;
    end
  end

`ifdef BICUBIC_SAT_COUNT_EN
  logic [NUM_PH-1:0] sat_ph;
`endif

  for (genvar p = 0; p < NUM_PH; p++) begin : g_lane
    bicubic_round_clamp #(.IN_W(IN_W), .FRAC(FRAC), .PIX_W(PIX_W)) u_rc (
      .ws  (h[p]),
      .pix (pix_ph[p])
`ifdef BICUBIC_SAT_COUNT_EN
      ,
      .sat (sat_ph[p])
`endif
    );
  end

  assign out_pix = pix_ph[ph];

`ifdef BICUBIC_SAT_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        sat_cnt <= '0;
    else if (xfer && sat_ph[ph] && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
  end
`endif
endmodule
